// File: rtl/clock_reset_pkg.sv
// Shared types and width helpers for the post-PLL clock and reset manager.
package clock_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_NUM_CHANNELS       = 4;
  localparam int DEF_DIV_WIDTH          = 16;
  localparam int DEF_DIV                = 1;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_LOSS_FILTER_CYCLES = 4;
  localparam int DEF_COUNT_WIDTH        = 8;

  // max(1, $clog2(n)): a counter or index never collapses to zero bits
  function automatic int calc_ch_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CH_W   = calc_ch_w(DEF_NUM_CHANNELS);
  localparam int DEF_STAB_W = calc_ch_w(DEF_LOCK_STABLE_CYCLES);
  localparam int DEF_HOLD_W = calc_ch_w(DEF_RESET_HOLD_CYCLES);
  localparam int DEF_LOSS_W = calc_ch_w(DEF_LOSS_FILTER_CYCLES);

endpackage

// File: rtl/clock_enable_divider.sv
// One clock-enable channel: shadow/active divisor pair and a wrap counter
// that strobes on count zero while the system is running.
module clock_enable_divider
  import clock_reset_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic                 i_clock_in,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_value,
  output logic                 o_strobe
);

  logic [DIV_WIDTH-1:0] r_shadow;
  logic [DIV_WIDTH-1:0] r_active;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [DIV_WIDTH-1:0] w_last;
  logic                 w_wrap;

  // A divisor of zero behaves like one, so its last count is also zero
  assign w_last = (r_active == '0) ? '0 : r_active - DIV_WIDTH'(1);
  assign w_wrap = (r_div_cnt == w_last);

  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_shadow <= DIV_WIDTH'(DEFAULT_DIV);
    end else if (i_load) begin
      r_shadow <= i_value;
    end
  end

  // The active divisor only changes on a wrap, so a period is never cut short
  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_active  <= DIV_WIDTH'(DEFAULT_DIV);
      r_div_cnt <= '0;
    end else if (!i_run) begin
      r_active  <= r_shadow;
      r_div_cnt <= '0;
    end else if (w_wrap) begin
      r_active  <= r_shadow;
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  assign o_strobe = i_run && (r_div_cnt == '0);

endmodule

// File: rtl/clock_reset_manager.sv
// Qualifies the asynchronous PLL lock, sequences a stretched system reset
// and drives phase-aligned programmable clock-enable strobes.
module clock_reset_manager
  import clock_reset_pkg::*;
#(
  parameter int NUM_CHANNELS       = DEF_NUM_CHANNELS,
  parameter int DIV_WIDTH          = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV        = DEF_DIV,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int LOSS_FILTER_CYCLES = DEF_LOSS_FILTER_CYCLES,
  parameter int COUNT_WIDTH        = DEF_COUNT_WIDTH
) (
  input  logic                                 i_clock_in,
  input  logic                                 i_reset,
  input  logic                                 i_pll_locked,
  input  logic                                 i_div_load,
  input  logic [calc_ch_w(NUM_CHANNELS)-1:0]   i_div_channel,
  input  logic [DIV_WIDTH-1:0]                 i_div_value,
  output logic                                 o_reset_out,
  output logic                                 o_ready,
  output logic [NUM_CHANNELS-1:0]              o_clk_enable,
  output logic [COUNT_WIDTH-1:0]               o_lock_loss_count
);

  localparam int CH_W   = calc_ch_w(NUM_CHANNELS);
  localparam int STAB_W = calc_ch_w(LOCK_STABLE_CYCLES);
  localparam int HOLD_W = calc_ch_w(RESET_HOLD_CYCLES);
  localparam int LOSS_W = calc_ch_w(LOSS_FILTER_CYCLES);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER_CYCLES - 1);

  logic                   r_sync1;
  logic                   r_locked_s;
  state_t                 r_state;
  state_t                 w_next_state;
  logic [STAB_W-1:0]      r_stab_cnt;
  logic [STAB_W-1:0]      w_stab_next;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [HOLD_W-1:0]      w_hold_next;
  logic [LOSS_W-1:0]      r_loss_cnt;
  logic [LOSS_W-1:0]      w_loss_next;
  logic                   w_loss_event;
  logic                   r_reset_out;
  logic                   r_ready;
  logic [COUNT_WIDTH-1:0] r_lock_loss_count;
  logic                   w_run;

  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= i_pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Counters restart from zero whenever they are not actively advancing
  always_comb begin
    w_next_state = r_state;
    w_stab_next  = '0;
    w_hold_next  = '0;
    w_loss_next  = '0;
    w_loss_event = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (r_locked_s) w_next_state = STABILISE;
      end
      STABILISE: begin
        if (!r_locked_s)               w_next_state = WAIT_LOCK;
        else if (r_stab_cnt == STAB_LAST) w_next_state = HOLD;
        else                           w_stab_next  = r_stab_cnt + STAB_W'(1);
      end
      HOLD: begin
        if (!r_locked_s)               w_next_state = WAIT_LOCK;
        else if (r_hold_cnt == HOLD_LAST) w_next_state = RUN;
        else                           w_hold_next  = r_hold_cnt + HOLD_W'(1);
      end
      RUN: begin
        if (!r_locked_s) begin
          if (r_loss_cnt == LOSS_LAST) begin
            w_next_state = WAIT_LOCK;
            w_loss_event = 1'b1;
          end else begin
            w_loss_next = r_loss_cnt + LOSS_W'(1);
          end
        end
      end
      default: w_next_state = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= WAIT_LOCK;
      r_stab_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_loss_cnt  <= '0;
      r_reset_out <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_stab_cnt  <= w_stab_next;
      r_hold_cnt  <= w_hold_next;
      r_loss_cnt  <= w_loss_next;
      r_reset_out <= (w_next_state != RUN);
      r_ready     <= (w_next_state == RUN);
    end
  end

  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_lock_loss_count <= '0;
    end else if (w_loss_event && (r_lock_loss_count != '1)) begin
      r_lock_loss_count <= r_lock_loss_count + COUNT_WIDTH'(1);
    end
  end

  assign w_run = (r_state == RUN);

  // Exact-match decode: channel codes at or beyond NUM_CHANNELS select nothing
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic w_load;
    assign w_load = i_div_load && (i_div_channel == CH_W'(gi));

    clock_enable_divider #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
      .i_clock_in (i_clock_in),
      .i_reset    (i_reset),
      .i_run      (w_run),
      .i_load     (w_load),
      .i_value    (i_div_value),
      .o_strobe   (o_clk_enable[gi])
    );
  end

  assign o_reset_out       = r_reset_out;
  assign o_ready           = r_ready;
  assign o_lock_loss_count = r_lock_loss_count;

endmodule
